// File: rtl/i8080_fetch.sv
`default_nettype none
// ============================================================================
// Module   : i8080_fetch
// Brief    : 8080 fetch/byte-align stage. 16-bit words go into an 8-byte
//            queue; whole 1/2/3-byte instructions are handed to decode.
//            Optional HLT stop is enabled by defining I8080_FETCH_HALT_EN.
// Revision : 1.0
// ============================================================================
module i8080_fetch (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_ren,
    output logic [14:0] mem_raddr,
    input  logic [15:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [23:0] d_ins,
    output logic [1:0]  d_len,
    output logic [15:0] d_pc
);
    logic [7:0]  r_q [0:7];
    logic [2:0]  r_head;
    logic [2:0]  r_tail;
    logic [3:0]  r_count;
    logic [14:0] r_fetch_pc;
    logic        r_inflight;
    logic        r_skip_lo;
    logic [15:0] r_head_pc;

    logic        w_halted;
    logic        w_flush;
    logic [7:0]  w_op;
    logic [2:0]  w_head1;
    logic [2:0]  w_head2;
    logic [2:0]  w_tail_hi;
    logic [3:0]  w_occ;
    logic        w_pop;
    logic        w_push_lo;
    logic        w_push_hi;
    logic [1:0]  w_push_n;
    logic [1:0]  w_pop_n;

    function automatic logic [1:0] f_len(input logic [7:0] op);
        logic [1:0] len;
        len = 2'd1;
        if ((op[7:6] == 2'b00 && op[3:0] == 4'b0001) ||
            (op[7:6] == 2'b11 && (op[2:0] == 3'b010 || op[2:0] == 3'b100)))
            len = 2'd3;
        else if (op == 8'h22 || op == 8'h2A || op == 8'h32 || op == 8'h3A ||
                 op == 8'hC3 || op == 8'hCB || op == 8'hCD || op == 8'hDD ||
                 op == 8'hED || op == 8'hFD)
            len = 2'd3;
        // 00xxx110 (MVI) and 11xxx110 (ALU immediates C6..FE)
        else if (op[2:0] == 3'b110 && (op[7:6] == 2'b00 || op[7:6] == 2'b11))
            len = 2'd2;
        else if (op == 8'hD3 || op == 8'hDB)
            len = 2'd2;
        return len;
    endfunction

    always_comb begin
        w_op      = r_q[r_head];
        w_head1   = r_head + 3'd1;
        w_head2   = r_head + 3'd2;
        d_len     = f_len(w_op);
        d_ins     = {w_op,
                     (d_len == 2'd1) ? 8'h00 : r_q[w_head1],
                     (d_len == 2'd3) ? r_q[w_head2] : 8'h00};
        d_pc      = r_head_pc;
        d_valid   = !w_halted && (r_count != 4'd0) && (r_count >= {2'b00, d_len});
        mem_raddr = r_fetch_pc;
        // Reads in flight are counted as already occupying their two slots
        w_occ     = r_count + {2'b00, r_inflight, 1'b0};
        mem_ren   = rst_n && !w_halted && !redirect_valid && (w_occ <= 4'd6);
        w_pop     = d_valid && d_ready && !redirect_valid;
        w_pop_n   = w_pop ? d_len : 2'd0;
        w_push_lo = r_inflight && !w_halted && !r_skip_lo;
        w_push_hi = r_inflight && !w_halted;
        w_push_n  = {1'b0, w_push_lo} + {1'b0, w_push_hi};
        w_tail_hi = r_tail + {2'b00, w_push_lo};
    end

`ifdef I8080_FETCH_HALT_EN
    logic r_halted;

    assign w_halted = r_halted;
    assign w_flush  = w_pop && (w_op == 8'h76);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
        end else if (redirect_valid) begin
            r_halted <= 1'b0;
        end else if (w_flush) begin
            r_halted <= 1'b1;
        end
    end
`else
    assign w_halted = 1'b0;
    assign w_flush  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) r_q[i] <= 8'h00;
            r_head     <= 3'd0;
            r_tail     <= 3'd0;
            r_count    <= 4'd0;
            r_fetch_pc <= 15'd0;
            r_inflight <= 1'b0;
            r_skip_lo  <= 1'b0;
            r_head_pc  <= 16'h0000;
        end else begin
            r_inflight <= mem_ren;
            if (mem_ren) r_fetch_pc <= r_fetch_pc + 15'd1;

            if (redirect_valid) begin
                r_head     <= 3'd0;
                r_tail     <= 3'd0;
                r_count    <= 4'd0;
                r_head_pc  <= redirect_pc;
                r_fetch_pc <= redirect_pc[15:1];
                r_skip_lo  <= redirect_pc[0];
            end else if (w_flush) begin
                r_head    <= 3'd0;
                r_tail    <= 3'd0;
                r_count   <= 4'd0;
                r_head_pc <= r_head_pc + {14'd0, d_len};
                if (r_inflight) r_skip_lo <= 1'b0;
            end else begin
                if (r_inflight) r_skip_lo <= 1'b0;
                if (w_push_lo) r_q[r_tail] <= mem_rdata[7:0];
                if (w_push_hi) r_q[w_tail_hi] <= mem_rdata[15:8];
                r_tail <= r_tail + {1'b0, w_push_n};
                if (w_pop) begin
                    r_head    <= r_head + {1'b0, d_len};
                    r_head_pc <= r_head_pc + {14'd0, d_len};
                end
                r_count <= r_count + {2'b00, w_push_n} - {2'b00, w_pop_n};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i8080_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_i8080_fetch
// Brief    : Self-checking bench for i8080_fetch against an instruction-stream
//            model of byte memory. Honors I8080_FETCH_HALT_EN.
// Revision : 1.0
// ============================================================================
module tb_i8080_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_ren;
    logic [14:0] mem_raddr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        d_valid;
    logic        d_ready;
    logic [23:0] d_ins;
    logic [1:0]  d_len;
    logic [15:0] d_pc;

    i8080_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_ren        (mem_ren),
        .mem_raddr      (mem_raddr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .d_valid        (d_valid),
        .d_ready        (d_ready),
        .d_ins          (d_ins),
        .d_len          (d_len),
        .d_pc           (d_pc)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];

    // One-cycle-latency word memory; idle cycles return junk that must never be queued
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= {mem[{mem_raddr, 1'b1}], mem[{mem_raddr, 1'b0}]};
        else         mem_rdata <= 16'hDEAD;
    end

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_issue  = 0;
    int          n_xfer   = 0;
    logic [15:0] model_pc;
    logic        model_halted;
    logic        hold_pending;
    logic [15:0] hold_pc;
    logic [23:0] hold_ins;
    logic        cyc_ren;
    logic [14:0] cyc_raddr;
    logic        cyc_valid;
    logic [23:0] last_ins;
    logic [1:0]  last_len;
    logic [15:0] last_pc;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_len(input logic [7:0] op);
        if (op inside {8'h22, 8'h2A, 8'h32, 8'h3A, 8'hC3, 8'hCB, 8'hCD,
                       8'hDD, 8'hED, 8'hFD}) return 2'd3;
        if (op[7:6] == 2'd0 && op[3:0] == 4'h1) return 2'd3;
        if (op[7:6] == 2'd3 && (op[2:0] == 3'd2 || op[2:0] == 3'd4)) return 2'd3;
        if (op inside {8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6,
                       8'hFE, 8'hD3, 8'hDB}) return 2'd2;
        if (op[7:6] == 2'd0 && op[2:0] == 3'd6) return 2'd2;
        return 2'd1;
    endfunction

    function automatic logic [23:0] ref_ins(input logic [15:0] pc, input logic [1:0] len);
        logic [15:0] p1;
        logic [15:0] p2;
        p1 = pc + 16'd1;
        p2 = pc + 16'd2;
        return {mem[pc], (len >= 2'd2) ? mem[p1] : 8'h00, (len == 2'd3) ? mem[p2] : 8'h00};
    endfunction

    // Called at a falling edge: drive inputs for the coming rising edge, sample, advance model
    task automatic step(input logic rdy, input logic redir, input logic [15:0] rpc);
        logic [1:0] len;
        d_ready        = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        cyc_ren   = mem_ren;
        cyc_raddr = mem_raddr;
        cyc_valid = d_valid;
        if (mem_ren) n_issue++;
        if (hold_pending) chk("hold", {d_valid, d_pc, d_ins}, {1'b1, hold_pc, hold_ins});
        if (model_halted) chk("halted", {d_valid, mem_ren}, 2'b00);
        hold_pending = 1'b0;
        if (redir) begin
            model_pc     = rpc;
            model_halted = 1'b0;
        end else if (d_valid && rdy) begin
            len = ref_len(mem[model_pc]);
            chk("xfer", {d_pc, 6'd0, d_len, d_ins}, {model_pc, 6'd0, len, ref_ins(model_pc, len)});
            last_ins = d_ins;
            last_len = d_len;
            last_pc  = d_pc;
            n_xfer++;
`ifdef I8080_FETCH_HALT_EN
            if (mem[model_pc] == 8'h76) model_halted = 1'b1;
`endif
            model_pc = model_pc + {14'd0, len};
        end else if (d_valid) begin
            hold_pending = 1'b1;
            hold_pc      = d_pc;
            hold_ins     = d_ins;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        model_pc     = 16'h0000;
        model_halted = 1'b0;
        hold_pending = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0; d_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
        model_reset();
        clear_mem();
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} = 48'h00_3E_42_C3_34_12;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ren",   mem_ren,   1'b0);
        chk("rst_raddr", mem_raddr, 15'd0);
        chk("rst_valid", d_valid,   1'b0);
        chk("rst_ins",   d_ins,     24'h0);
        chk("rst_len",   d_len,     2'd1);
        chk("rst_pc",    d_pc,      16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic stream: three instruction lengths
        step(1, 0, 0); chk("c0_ren", {cyc_ren, cyc_raddr}, {1'b1, 15'd0});
        step(1, 0, 0); chk("c1_valid", cyc_valid, 1'b0);
        step(1, 0, 0); chk("c2_valid", cyc_valid, 1'b1);
        chk("x1", {last_ins, last_len, last_pc}, {24'h000000, 2'd1, 16'h0000});
        step(1, 0, 0); chk("x2", {last_ins, last_len, last_pc}, {24'h3E4200, 2'd2, 16'h0001});
        step(1, 0, 0); chk("x3", {last_ins, last_len, last_pc}, {24'hC33412, 2'd3, 16'h0003});

        // Decode stalled: queue fills to 8 bytes and reads stop
        {mem[0], mem[1], mem[2]} = 24'hCD_11_22;
        do_reset();
        n_issue = 0;
        for (int i = 0; i < 20; i++) step(0, 0, 0);
        chk("stall_issues", n_issue, 4);
        chk("stall_ren", cyc_ren, 1'b0);
        chk("stall_head", {d_valid, d_ins}, {1'b1, 24'hCD1122});
        step(1, 0, 0); chk("stall_x", {last_ins, last_pc}, {24'hCD1122, 16'h0000});

        // Redirect while a read is in flight, then to an odd 3-byte target
        mem[16'h0100] = 8'hAA; mem[16'h0101] = 8'h07;
        {mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0203]} = 32'h99_C3_78_56;
        do_reset();
        step(1, 0, 0);
        step(1, 1, 16'h0101); chk("rd_sup", cyc_ren, 1'b0);
        step(1, 0, 0); chk("rd_n1", {cyc_ren, cyc_raddr}, {1'b1, 15'h0080});
        step(1, 0, 0); chk("rd_n2", cyc_valid, 1'b0);
        step(1, 0, 0); chk("rd_n3", {cyc_valid, last_pc, last_ins[23:16]}, {1'b1, 16'h0101, 8'h07});
        step(1, 1, 16'h0201);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0); chk("rd3_wait", cyc_valid, 1'b0);
        end
        step(1, 0, 0); chk("rd3_n4", {cyc_valid, last_pc, last_ins}, {1'b1, 16'h0201, 24'hC37856});

        // Address wrap at the top of memory
        step(1, 1, 16'hFFFE);
        step(1, 0, 0); chk("wrap_a0", {cyc_ren, cyc_raddr}, {1'b1, 15'h7FFF});
        step(1, 0, 0); chk("wrap_a1", {cyc_ren, cyc_raddr}, {1'b1, 15'h0000});
        step(1, 0, 0); chk("wrap_p0", last_pc, 16'hFFFE);
        step(1, 0, 0); chk("wrap_p1", last_pc, 16'hFFFF);
        step(1, 0, 0); chk("wrap_p2", last_pc, 16'h0000);

        // Sustained 2 bytes/cycle with 2-byte instructions
        for (int a = 16'h1000; a < 16'h1100; a += 2) begin
            mem[a] = 8'h06; mem[a + 1] = 8'h55;
        end
        step(1, 1, 16'h1000);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        n_xfer = 0;
        for (int i = 0; i < 20; i++) step(1, 0, 0);
        chk("throughput", n_xfer, 20);

        // Asynchronous reset in the middle of a stream
        step(0, 1, 16'h0101);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        chk("mid_pre", cyc_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst", {d_valid, mem_ren, d_pc}, {1'b0, 1'b0, 16'h0000});
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0); chk("mid_ren", {cyc_ren, cyc_raddr}, {1'b1, 15'd0});
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        chk("mid_x", last_pc, 16'h0000);

`ifdef I8080_FETCH_HALT_EN
        clear_mem();
        mem[0] = 8'h76;
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        chk("hlt_x", {last_ins, last_pc}, {24'h760000, 16'h0000});
        n_issue = 0;
        for (int i = 0; i < 6; i++) step(1, 0, 0);
        chk("hlt_noissue", n_issue, 0);
        step(1, 1, 16'h0001);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        chk("hlt_resume", {last_ins, last_pc}, {24'h000000, 16'h0001});
`endif

        // Random program, random back-pressure and redirects
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        do_reset();
        n_xfer = 0;
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, 16'($urandom));
        chk("rand_progress", n_xfer >= 300, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
